mod_logic_pipe_2xnb: RTL
========================

// Module: mod_logic_pipe_2xnb
// PURPOSE
//  Parametrised, pipelined two-operand bitwise logic unit: AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS on WIDTH-bit operands.
//  Successor to the fixed 6-bit combinational XOR stage, adding op select, result flags, valid/ready handshake,
//  configurable pipeline depth and a completed-operation counter. Sits in the ALU logic-op path between operand
//  registers and the result mux.
// PARAMETERS
//  WIDTH       6   operand/result width in bits (>=1)
//  PIPE_DEPTH  2   register stages from input accept to output (1..4); also max in-flight ops
//  CNT_W       16  width of completed-operation counter CNT
// PORTS
//  CLK        in   1         rising-edge clock
//  RST        in   1         synchronous reset, active-high
//  A          in   WIDTH     operand A
//  B          in   WIDTH     operand B
//  OP         in   3         op code (see BEHAVIOUR)
//  IN_VALID   in   1         A/B/OP valid
//  IN_READY   out  1         unit accepts input this cycle
//  Y          out  WIDTH     result
//  ZERO       out  1         Y == 0
//  PARITY     out  1         ^Y (odd number of ones)
//  ALL_ONES   out  1         &Y
//  OUT_VALID  out  1         Y/flags valid
//  OUT_READY  in   1         downstream accepts result
//  CNT        out  CNT_W     number of results handed off (OUT_VALID & OUT_READY), wraps
// BEHAVIOUR
//  - One clock domain; reset synchronous and active-high.
//  - OP: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (B ignored), 111 PASS A. All codes legal.
//  - Input accepted when IN_VALID & IN_READY; result computed combinationally from A/B/OP, captured with flags into stage 0.
//  - Stages 0..PIPE_DEPTH-1 each hold {valid, Y, ZERO, PARITY, ALL_ONES}; last stage drives outputs directly (no comb. path A->Y).
//  - Stage k advances when stage k+1 empty or advancing; last stage advances when OUT_READY. Bubbles collapse.
//  - IN_READY = ~RST & (~valid[0] | stage0 advances). Combinational from OUT_READY permitted; no comb. path IN_VALID->IN_READY.
//  - Latency: exactly PIPE_DEPTH cycles accept->OUT_VALID with no stall. Throughput: 1 op/cycle when OUT_READY held high.
//  - Stall: OUT_VALID & ~OUT_READY holds Y and flags stable; pipeline fills; at most PIPE_DEPTH ops in flight; no loss/duplication.
//  - Ordering: results emerge in accept order.
//  - CNT increments on OUT_VALID & OUT_READY; wraps 2^CNT_W-1 -> 0.
//  - Reset (incl. mid-operation): all valid bits 0, Y/flags 0, CNT 0, IN_READY 0 while RST high; in-flight ops dropped.
//    First accept possible in the cycle after RST deasserts.
//  - Flags always consistent with Y of the same stage; flags 0 whenever OUT_VALID is 0 after reset.
// STRUCTURE
//  - Shared package mod_alu_pkg: localparams OP_AND..OP_PASS (3-bit codes) and OP_W = 3, reused by other ALU blocks.
//  - Sub-module mod_logic_core_nb #(WIDTH): combinational A,B,OP -> Y,ZERO,PARITY,ALL_ONES; instanced once before stage 0.
//  - Pipeline stages via generate loop over PIPE_DEPTH; counter inline.
// TESTING (WIDTH=6, PIPE_DEPTH=2, CNT_W=16 unless noted)
//  1. RST high 2 cycles, then low -> OUT_VALID=0, Y=0, flags 0, CNT=0; IN_READY=0 during RST, 1 the cycle after.
//  2. A=6'b101010, B=6'b110011, OP=010, OUT_READY=1 -> 2 cycles later OUT_VALID=1, Y=6'b011001, PARITY=1, ZERO=0, CNT->1.
//  3. Four back-to-back ops (AND,OR,NAND,XNOR on A=6'h15,B=6'h0F), OUT_READY=1 -> Y=6'h05,6'h1F,6'h3A,6'h25 on 4 consecutive cycles, CNT=4.
//  4. OUT_READY=0, offer 3 ops -> 2 accepted, IN_READY=0, Y stable; OUT_READY=1 -> all 3 delivered in order, none duplicated.
//  5. XOR A=B=6'h2A -> Y=0, ZERO=1; NOT A=6'h00 -> Y=6'h3F, ALL_ONES=1, PARITY=0.
//  6. RST pulse with 2 ops in flight -> OUT_VALID=0 next cycle, CNT=0, dropped ops never appear; CNT_W=2 run 5 handoffs -> CNT=1.

Source files
------------

// File: rtl/mod_alu_pkg.sv
// Shared ALU definitions: logic-op codes and op-code width.
// Used by the logic pipe and by other ALU blocks that decode the same op field.
package mod_alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/mod_logic_core_nb.sv
// Combinational bitwise logic core.
// Ports:
//   a, b      operands (WIDTH bits); b is ignored for NOT and PASS
//   op        op code (mod_alu_pkg OP_*)
//   y         result
//   zero      y == 0
//   parity    odd number of ones in y
//   all_ones  every bit of y set
module mod_logic_core_nb
    import mod_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic             all_ones
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
        endcase
    end

    assign zero     = ~|y;
    assign parity   = ^y;
    assign all_ones = &y;

endmodule

// File: rtl/mod_logic_pipe_2xnb.sv
// Pipelined bitwise logic unit with valid/ready handshake on both sides.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   A, B, OP, IN_VALID       input operation; IN_READY accepts it
//   Y, ZERO, PARITY,
//   ALL_ONES, OUT_VALID      registered result and flags from the last stage
//   OUT_READY                downstream accepts the result
//   CNT                      wrapping count of handed-off results
module mod_logic_pipe_2xnb
    import mod_alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  OP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO,
    output logic             PARITY,
    output logic             ALL_ONES,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] CNT
);

    // Stage payload: {y, zero, parity, all_ones}
    localparam int unsigned SW = WIDTH + 3;

    logic [WIDTH-1:0] core_y;
    logic             core_zero;
    logic             core_parity;
    logic             core_all_ones;
    logic [SW-1:0]    stage_in;

    logic             vld_q  [PIPE_DEPTH];
    logic [SW-1:0]    data_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] free;
    logic             accept;
    logic [CNT_W-1:0] cnt_q;

    mod_logic_core_nb #(
        .WIDTH (WIDTH)
    ) u_core (
        .a        (A),
        .b        (B),
        .op       (OP),
        .y        (core_y),
        .zero     (core_zero),
        .parity   (core_parity),
        .all_ones (core_all_ones)
    );

    assign stage_in = {core_y, core_zero, core_parity, core_all_ones};

    // A stage may load when it or any later stage is empty (bubbles collapse),
    // or when the whole tail is full but the output is being taken.
    logic full_tail;
    always_comb begin
        free      = '0;
        full_tail = 1'b1;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            full_tail = 1'b1;
            for (int j = k; j < PIPE_DEPTH; j++) begin
                full_tail = full_tail & vld_q[j];
            end
            free[k] = ~full_tail | OUT_READY;
        end
    end

    assign IN_READY = ~RST & free[0];
    assign accept   = IN_VALID & IN_READY;

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        logic          src_vld;
        logic [SW-1:0] src_data;

        if (k == 0) begin : g_first
            assign src_vld  = accept;
            assign src_data = stage_in;
        end else begin : g_rest
            assign src_vld  = vld_q[k-1];
            assign src_data = data_q[k-1];
        end

        // Bubbles load zero payload so flags read 0 whenever the stage is empty.
        always_ff @(posedge CLK) begin
            if (RST) begin
                vld_q[k]  <= 1'b0;
                data_q[k] <= '0;
            end else if (free[k]) begin
                vld_q[k]  <= src_vld;
                data_q[k] <= src_vld ? src_data : '0;
            end
        end
    end

    assign OUT_VALID                  = vld_q[PIPE_DEPTH-1];
    assign {Y, ZERO, PARITY, ALL_ONES} = data_q[PIPE_DEPTH-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (OUT_VALID & OUT_READY) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign CNT = cnt_q;

endmodule
